// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types and constants for the register-file write-back controller.
package regfile_wb_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    // One outstanding load: destination, returned data, data-has-arrived flag.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
        logic              done;
    } ldq_entry_t;

endpackage

// File: rtl/regfile_wb_ctrl_ld_queue.sv
// In-order load queue with head (oldest), fill (oldest not done) and tail
// (next allocation) pointers.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   i_alloc, i_alloc_rd    allocate an entry at tail (caller guarantees not full)
//   i_fill, i_fill_data    store returned data at fill (caller guarantees o_fill_ok)
//   i_retire               pop head (caller guarantees head valid and done)
//   o_head, o_head_valid   oldest entry
//   o_count                occupied entries
//   o_fill_ok              an entry allocated in an earlier cycle awaits data
//   o_ent_rd, o_ent_valid  per-entry destination/valid for hazard compare
module regfile_wb_ctrl_ld_queue
    import regfile_wb_ctrl_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_alloc,
    input  logic [REG_AW-1:0]             i_alloc_rd,
    input  logic                          i_fill,
    input  logic [XLEN-1:0]               i_fill_data,
    input  logic                          i_retire,
    output ldq_entry_t                    o_head,
    output logic                          o_head_valid,
    output logic [CW-1:0]                 o_count,
    output logic                          o_fill_ok,
    output logic [DEPTH-1:0][REG_AW-1:0]  o_ent_rd,
    output logic [DEPTH-1:0]              o_ent_valid
);

    ldq_entry_t        r_ent [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_fill;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    // Entries allocated but not yet done; registered, so a same-cycle
    // allocation is never fillable.
    logic [CW-1:0]     r_unfilled;

    // Pointer/entry update; alloc, fill and retire never touch the same slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_fill     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
            r_valid    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            if (i_alloc) begin
                r_ent[r_tail].rd   <= i_alloc_rd;
                r_ent[r_tail].done <= 1'b0;
                r_valid[r_tail]    <= 1'b1;
                r_tail             <= r_tail + PW'(1);
            end
            if (i_fill) begin
                r_ent[r_fill].data <= i_fill_data;
                r_ent[r_fill].done <= 1'b1;
                r_fill             <= r_fill + PW'(1);
            end
            if (i_retire) begin
                r_ent[r_head].done <= 1'b0;
                r_valid[r_head]    <= 1'b0;
                r_head             <= r_head + PW'(1);
            end
            r_count    <= r_count + CW'(i_alloc) - CW'(i_retire);
            r_unfilled <= r_unfilled + CW'(i_alloc) - CW'(i_fill);
        end
    end

    // Per-entry destination view for the hazard comparators.
    always_comb begin
        o_ent_rd = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            o_ent_rd[i] = r_ent[i].rd;
        end
    end

    assign o_head       = r_ent[r_head];
    assign o_head_valid = r_valid[r_head];
    assign o_count      = r_count;
    assign o_fill_ok    = (r_unfilled != '0);
    assign o_ent_valid  = r_valid;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller owning the register file write port. Merges ALU
// results (priority) with in-order load returns and flags decode hazards.
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   alu_valid/alu_rd/alu_data         single-cycle ALU result
//   ld_issue_valid/ld_issue_rd        load issue; ld_issue_ready = queue not full
//   ld_resp_valid/ld_resp_data        in-order load data return
//   rs1_addr/rs2_addr/rd_addr         decode operands; hazard is combinational
//   wr_en/wr_addr/wr_data             registered register-file write port
//   ldq_count                         occupied queue entries
//   ld_resp_err                       sticky: response with nothing to fill
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter  int unsigned LDQ_DEPTH = 4,
    localparam int unsigned CW        = $clog2(LDQ_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              ld_issue_valid,
    input  logic [REG_AW-1:0] ld_issue_rd,
    output logic              ld_issue_ready,
    input  logic              ld_resp_valid,
    input  logic [XLEN-1:0]   ld_resp_data,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic [REG_AW-1:0] rd_addr,
    output logic              hazard,
    output logic              wr_en,
    output logic [REG_AW-1:0] wr_addr,
    output logic [XLEN-1:0]   wr_data,
    output logic [CW-1:0]     ldq_count,
    output logic              ld_resp_err
);

    ldq_entry_t                        w_head;
    logic                              w_head_valid;
    logic [CW-1:0]                     w_count;
    logic                              w_fill_ok;
    logic [LDQ_DEPTH-1:0][REG_AW-1:0]  w_ent_rd;
    logic [LDQ_DEPTH-1:0]              w_ent_valid;
    logic                              w_issue;
    logic                              w_fill;
    logic                              w_retire;
    logic                              w_hazard;
    logic [2:0][REG_AW-1:0]            w_srcs;

    logic                              r_wr_en;
    logic [REG_AW-1:0]                 r_wr_addr;
    logic [XLEN-1:0]                   r_wr_data;
    logic                              r_err;

    // Ready comes from the registered count only; no retire look-ahead.
    assign ld_issue_ready = (w_count < CW'(LDQ_DEPTH));
    assign w_issue        = ld_issue_valid && ld_issue_ready;
    assign w_fill         = ld_resp_valid && w_fill_ok;
    // ALU owns the write port whenever it is valid; loads wait.
    assign w_retire       = !alu_valid && w_head_valid && w_head.done;

    regfile_wb_ctrl_ld_queue #(
        .DEPTH (LDQ_DEPTH)
    ) u_ld_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_alloc      (w_issue),
        .i_alloc_rd   (ld_issue_rd),
        .i_fill       (w_fill),
        .i_fill_data  (ld_resp_data),
        .i_retire     (w_retire),
        .o_head       (w_head),
        .o_head_valid (w_head_valid),
        .o_count      (w_count),
        .o_fill_ok    (w_fill_ok),
        .o_ent_rd     (w_ent_rd),
        .o_ent_valid  (w_ent_valid)
    );

    // Write port register with x0 suppression, plus sticky response error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            if (alu_valid) begin
                r_wr_en   <= (alu_rd != REG_ZERO);
                r_wr_addr <= alu_rd;
                r_wr_data <= alu_data;
            end else if (w_retire) begin
                r_wr_en   <= (w_head.rd != REG_ZERO);
                r_wr_addr <= w_head.rd;
                r_wr_data <= w_head.data;
            end
            if (ld_resp_valid && !w_fill_ok) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_srcs = {rd_addr, rs2_addr, rs1_addr};

    // Stall if any nonzero operand matches a queued load or the write in flight.
    always_comb begin
        w_hazard = 1'b0;
        for (int a = 0; a < 3; a++) begin
            if (w_srcs[a] != REG_ZERO) begin
                if (r_wr_en && (r_wr_addr == w_srcs[a])) begin
                    w_hazard = 1'b1;
                end
                for (int i = 0; i < int'(LDQ_DEPTH); i++) begin
                    if (w_ent_valid[i] && (w_ent_rd[i] == w_srcs[a])) begin
                        w_hazard = 1'b1;
                    end
                end
            end
        end
    end

    assign hazard      = w_hazard;
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign ldq_count   = w_count;
    assign ld_resp_err = r_err;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: ALU vector table plus load sequences.
module tb_regfile_wb_ctrl;
    import regfile_wb_ctrl_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              alu_valid;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              ld_issue_valid;
    logic [REG_AW-1:0] ld_issue_rd;
    logic              ld_issue_ready;
    logic              ld_resp_valid;
    logic [XLEN-1:0]   ld_resp_data;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] rd_addr;
    logic              hazard;
    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic [XLEN-1:0]   wr_data;
    logic [CW-1:0]     ldq_count;
    logic              ld_resp_err;

    always #5 clk = ~clk;

    regfile_wb_ctrl #(.LDQ_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid      (alu_valid),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_rd    (ld_issue_rd),
        .ld_issue_ready (ld_issue_ready),
        .ld_resp_valid  (ld_resp_valid),
        .ld_resp_data   (ld_resp_data),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rd_addr        (rd_addr),
        .hazard         (hazard),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .ldq_count      (ldq_count),
        .ld_resp_err    (ld_resp_err)
    );

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic        av;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  rs1;
        logic        en;
        logic        hz;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    vec_t vecs [7];
    wr_t  exp_q [$];
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        alu_valid      = 1'b0;
        alu_rd         = '0;
        alu_data       = '0;
        ld_issue_valid = 1'b0;
        ld_issue_rd    = '0;
        ld_resp_valid  = 1'b0;
        ld_resp_data   = '0;
        rs1_addr       = '0;
        rs2_addr       = '0;
        rd_addr        = '0;
    endtask

    function automatic logic [31:0] data_for(input int idx);
        return (idx < 3) ? (32'h101 + 32'(idx)) : (32'h200 + 32'(idx - 3));
    endfunction

    // Write-order scoreboard used during the wrap-around phase.
    always @(negedge clk) begin : mon
        wr_t e;
        if (mon_en && wr_en) begin
            if (exp_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL wrap_extra_write: got write to x%0d, none expected", wr_addr);
            end else begin
                e = exp_q.pop_front();
                check("wrap_addr", 32'(wr_addr), 32'(e.rd));
                check("wrap_data", wr_data, e.data);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int  n_iss;
        int  n_fill;
        int  unfilled;
        logic acc;

        vecs[0] = '{1'b1, 5'd5,  32'h0000_1234, 5'd5,  1'b1, 1'b1};
        vecs[1] = '{1'b1, 5'd0,  32'h0000_FFFF, 5'd0,  1'b0, 1'b0};
        vecs[2] = '{1'b0, 5'd0,  32'h0000_0000, 5'd5,  1'b0, 1'b0};
        vecs[3] = '{1'b1, 5'd31, 32'hA5A5_A5A5, 5'd31, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 5'd1,  32'h0000_0001, 5'd31, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 5'd2,  32'hCAFE_F00D, 5'd0,  1'b1, 1'b0};
        vecs[6] = '{1'b0, 5'd2,  32'h0000_0000, 5'd2,  1'b0, 1'b0};

        // Reset state
        idle();
        rst_n = 1'b0;
        rs1_addr = 5'd3; rs2_addr = 5'd3; rd_addr = 5'd3;
        tick();
        tick();
        check("rst_wr_en",   32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_ready",   32'(ld_issue_ready), 32'd1);
        check("rst_count",   32'(ldq_count), 32'd0);
        check("rst_err",     32'(ld_resp_err), 32'd0);
        check("rst_hazard",  32'(hazard), 32'd0);
        rst_n = 1'b1;
        idle();
        tick();

        // ALU-only vectors
        for (int i = 0; i < 7; i++) begin
            alu_valid = vecs[i].av;
            alu_rd    = vecs[i].rd;
            alu_data  = vecs[i].data;
            rs1_addr  = vecs[i].rs1;
            tick();
            check("alu_wr_en", 32'(wr_en), 32'(vecs[i].en));
            if (vecs[i].en) begin
                check("alu_wr_addr", 32'(wr_addr), 32'(vecs[i].rd));
                check("alu_wr_data", wr_data, vecs[i].data);
            end
            check("alu_hazard", 32'(hazard), 32'(vecs[i].hz));
        end
        idle();
        tick();

        // Load RAW: issue x3 at N, response at N+4, write at N+6
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd3;
        tick();
        ld_issue_valid = 1'b0; rs1_addr = 5'd3;
        settle();
        check("raw_hz_n1", 32'(hazard), 32'd1);
        check("raw_count", 32'(ldq_count), 32'd1);
        tick();
        tick();
        tick();
        ld_resp_valid = 1'b1; ld_resp_data = 32'hDEAD;
        settle();
        check("raw_hz_n4", 32'(hazard), 32'd1);
        tick();
        ld_resp_valid = 1'b0;
        check("raw_wr_en_n5", 32'(wr_en), 32'd0);
        check("raw_hz_n5", 32'(hazard), 32'd1);
        tick();
        check("raw_wr_en_n6", 32'(wr_en), 32'd1);
        check("raw_wr_addr",  32'(wr_addr), 32'd3);
        check("raw_wr_data",  wr_data, 32'hDEAD);
        check("raw_hz_n6",    32'(hazard), 32'd1);
        check("raw_count_n6", 32'(ldq_count), 32'd0);
        tick();
        check("raw_wr_en_n7", 32'(wr_en), 32'd0);
        check("raw_hz_n7",    32'(hazard), 32'd0);
        idle();

        // Collision: done load head loses to three ALU writes
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd9;
        tick();
        ld_issue_valid = 1'b0;
        ld_resp_valid = 1'b1; ld_resp_data = 32'h5555_5555;
        tick();
        ld_resp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h70 + 32'(k);
            tick();
            check("col_alu_en",   32'(wr_en), 32'd1);
            check("col_alu_addr", 32'(wr_addr), 32'd7);
            check("col_alu_data", wr_data, 32'h70 + 32'(k));
        end
        check("col_count_held", 32'(ldq_count), 32'd1);
        alu_valid = 1'b0;
        tick();
        check("col_ld_en",   32'(wr_en), 32'd1);
        check("col_ld_addr", 32'(wr_addr), 32'd9);
        check("col_ld_data", wr_data, 32'h5555_5555);
        check("col_count",   32'(ldq_count), 32'd0);
        tick();
        check("col_idle_en", 32'(wr_en), 32'd0);

        // Fill to capacity, 5th issue ignored
        for (int k = 0; k < 4; k++) begin
            ld_issue_valid = 1'b1; ld_issue_rd = 5'(10 + k);
            tick();
        end
        ld_issue_rd = 5'd14;
        settle();
        check("full_ready", 32'(ld_issue_ready), 32'd0);
        check("full_count", 32'(ldq_count), 32'd4);
        tick();
        ld_issue_valid = 1'b0;
        check("full_count_5th", 32'(ldq_count), 32'd4);
        rs1_addr = 5'd14;
        settle();
        check("full_hz_ignored", 32'(hazard), 32'd0);
        rs1_addr = 5'd13;
        settle();
        check("full_hz_last", 32'(hazard), 32'd1);
        rs1_addr = 5'd0;
        ld_resp_valid = 1'b1; ld_resp_data = 32'h100;
        tick();
        ld_resp_valid = 1'b0;
        tick();
        check("full_ret_en",    32'(wr_en), 32'd1);
        check("full_ret_addr",  32'(wr_addr), 32'd10);
        check("full_ret_data",  wr_data, 32'h100);
        check("full_ret_ready", 32'(ld_issue_ready), 32'd1);
        check("full_ret_count", 32'(ldq_count), 32'd3);

        // Wrap through 10 more loads; writes must follow issue order
        exp_q.delete();
        exp_q.push_back('{5'd10, 32'h100});
        for (int k = 0; k < 3; k++) exp_q.push_back('{5'(11 + k), data_for(k)});
        for (int k = 0; k < 10; k++) exp_q.push_back('{5'(16 + k), data_for(k + 3)});
        mon_en   = 1'b1;
        n_iss    = 0;
        n_fill   = 0;
        unfilled = 3;
        for (int c = 0; c < 80 && (n_iss < 10 || n_fill < 13); c++) begin
            ld_issue_valid = (n_iss < 10);
            ld_issue_rd    = 5'(16 + n_iss);
            ld_resp_valid  = (unfilled > 0);
            ld_resp_data   = data_for(n_fill);
            settle();
            acc = ld_issue_valid && ld_issue_ready;
            tick();
            if (acc) begin n_iss++; unfilled++; end
            if (ld_resp_valid) begin n_fill++; unfilled--; end
        end
        idle();
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) tick();
        tick();
        tick();
        mon_en = 1'b0;
        check("wrap_pending", 32'(exp_q.size()), 32'd0);
        check("wrap_count",   32'(ldq_count), 32'd0);
        check("wrap_err",     32'(ld_resp_err), 32'd0);

        // Response on empty queue
        ld_resp_valid = 1'b1; ld_resp_data = 32'hBAD;
        tick();
        ld_resp_valid = 1'b0;
        check("err_set",   32'(ld_resp_err), 32'd1);
        check("err_count", 32'(ldq_count), 32'd0);
        tick();
        check("err_no_wr", 32'(wr_en), 32'd0);
        tick();
        check("err_sticky", 32'(ld_resp_err), 32'd1);

        // Reset with two entries pending
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd4;
        tick();
        ld_issue_rd = 5'd6;
        tick();
        ld_issue_valid = 1'b0;
        check("mid_count", 32'(ldq_count), 32'd2);
        rs1_addr = 5'd4; rs2_addr = 5'd6;
        rst_n = 1'b0;
        tick();
        check("mid_rst_count", 32'(ldq_count), 32'd0);
        check("mid_rst_hz",    32'(hazard), 32'd0);
        check("mid_rst_err",   32'(ld_resp_err), 32'd0);
        check("mid_rst_ready", 32'(ld_issue_ready), 32'd1);
        rst_n = 1'b1;
        idle();
        ld_resp_valid = 1'b1; ld_resp_data = 32'h44;
        tick();
        ld_resp_valid = 1'b0;
        check("post_rst_err", 32'(ld_resp_err), 32'd1);
        tick();
        check("post_rst_no_wr", 32'(wr_en), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst2_err", 32'(ld_resp_err), 32'd0);

        // x0 load, then retire and issue in the same cycle
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd0;
        tick();
        ld_issue_valid = 1'b0;
        settle();
        check("x0_count", 32'(ldq_count), 32'd1);
        check("x0_hz",    32'(hazard), 32'd0);
        ld_resp_valid = 1'b1; ld_resp_data = 32'h77;
        tick();
        ld_resp_valid = 1'b0;
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd8;
        tick();
        ld_issue_valid = 1'b0;
        check("x0_issue_retire_count", 32'(ldq_count), 32'd1);
        check("x0_ret_no_wr",          32'(wr_en), 32'd0);
        tick();
        check("x0_no_wr", 32'(wr_en), 32'd0);
        rd_addr = 5'd8;
        settle();
        check("x8_hz", 32'(hazard), 32'd1);
        ld_resp_valid = 1'b1; ld_resp_data = 32'h88;
        tick();
        ld_resp_valid = 1'b0;
        tick();
        check("x8_wr_en",   32'(wr_en), 32'd1);
        check("x8_wr_addr", 32'(wr_addr), 32'd8);
        check("x8_wr_data", wr_data, 32'h88);
        check("x8_count",   32'(ldq_count), 32'd0);
        rd_addr = 5'd0;
        tick();

        // Same-cycle issue and response on an empty queue
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd12;
        ld_resp_valid  = 1'b1; ld_resp_data = 32'h99;
        tick();
        idle();
        check("same_cyc_err",   32'(ld_resp_err), 32'd1);
        check("same_cyc_count", 32'(ldq_count), 32'd1);
        tick();
        tick();
        check("same_cyc_no_wr", 32'(wr_en), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
